// File: rtl/gate_deadtime_driver.sv
// Two-leg gate driver with dead-time insertion, shoot-through fault latch,
// switching-state decode and +1-entry period measurement.
module gate_deadtime_driver #(
    parameter int unsigned DEAD_TIME = 5
) (
    input  logic        i_clock,
    input  logic        i_RESET,
    input  logic [3:0]  i_MOSFET,
    input  logic        i_clear_fault,
    output logic [3:0]  o_gate,
    output logic [1:0]  o_sigma,
    output logic        o_fault,
    output logic [15:0] o_period,
    output logic        o_period_valid
);

    localparam int unsigned CNT_W  = 8;
    localparam int unsigned PER_W  = 16;
    localparam int unsigned N_LEGS = 2;

    localparam logic [CNT_W-1:0] DT_C    = CNT_W'(DEAD_TIME);
    localparam logic [PER_W-1:0] PER_MAX = {PER_W{1'b1}};
    localparam logic [1:0]       SIG_POS = 2'b01;
    localparam logic [1:0]       SIG_NEG = 2'b11;
    localparam logic [1:0]       SIG_ZER = 2'b00;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ON_H = 2'd1,
        ON_L = 2'd2
    } leg_state_t;

    logic [3:0]       cmd_q;
    logic             clr_q;
    leg_state_t       state_q [N_LEGS];
    logic [CNT_W-1:0] cnt_q   [N_LEGS];
    logic [CNT_W-1:0] cnt_inc_c [N_LEGS];
    logic [N_LEGS-1:0] bad_c;
    logic             force_idle_c;
    logic             fault_d_c;
    logic [1:0]       sigma_dec_c;
    logic [1:0]       sigma_d_c;
    logic             pos_entry_c;
    logic             armed_q;
    logic [PER_W-1:0] per_cnt_q;

    // Input capture: every decision below works on these registered copies.
    always_ff @(posedge i_clock or negedge i_RESET) begin
        if (!i_RESET) begin
            cmd_q <= 4'b0000;
            clr_q <= 1'b0;
        end else begin
            cmd_q <= i_MOSFET;
            clr_q <= i_clear_fault;
        end
    end

    always_comb begin
        for (int i = 0; i < N_LEGS; i++) begin
            bad_c[i]     = cmd_q[i] & cmd_q[i+2];
            cnt_inc_c[i] = (cnt_q[i] >= DT_C) ? DT_C : cnt_q[i] + CNT_W'(1);
        end
        force_idle_c = o_fault | (|bad_c);
        // A new shoot-through command always beats a clear request.
        if (|bad_c)
            fault_d_c = 1'b1;
        else if (clr_q)
            fault_d_c = 1'b0;
        else
            fault_d_c = o_fault;
    end

    // Per-leg dead-time FSMs; a leg turns on on the edge its counter reaches DEAD_TIME.
    always_ff @(posedge i_clock or negedge i_RESET) begin
        if (!i_RESET) begin
            o_gate  <= 4'b0000;
            o_fault <= 1'b0;
            for (int i = 0; i < N_LEGS; i++) begin
                state_q[i] <= IDLE;
                cnt_q[i]   <= '0;
            end
        end else begin
            o_fault <= fault_d_c;
            for (int i = 0; i < N_LEGS; i++) begin
                if (force_idle_c) begin
                    state_q[i]  <= IDLE;
                    cnt_q[i]    <= '0;
                    o_gate[i]   <= 1'b0;
                    o_gate[i+2] <= 1'b0;
                end else begin
                    case (state_q[i])
                        IDLE: begin
                            cnt_q[i] <= cnt_inc_c[i];
                            if (cnt_inc_c[i] == DT_C) begin
                                if (cmd_q[i] && !cmd_q[i+2]) begin
                                    state_q[i] <= ON_H;
                                    o_gate[i]  <= 1'b1;
                                end else if (!cmd_q[i] && cmd_q[i+2]) begin
                                    state_q[i]  <= ON_L;
                                    o_gate[i+2] <= 1'b1;
                                end
                            end
                        end
                        ON_H: begin
                            if (!(cmd_q[i] && !cmd_q[i+2])) begin
                                state_q[i] <= IDLE;
                                cnt_q[i]   <= '0;
                                o_gate[i]  <= 1'b0;
                            end
                        end
                        ON_L: begin
                            if (!(!cmd_q[i] && cmd_q[i+2])) begin
                                state_q[i]  <= IDLE;
                                cnt_q[i]    <= '0;
                                o_gate[i+2] <= 1'b0;
                            end
                        end
                        default: begin
                            state_q[i]  <= IDLE;
                            cnt_q[i]    <= '0;
                            o_gate[i]   <= 1'b0;
                            o_gate[i+2] <= 1'b0;
                        end
                    endcase
                end
            end
        end
    end

    always_comb begin
        case (cmd_q)
            4'b1001: sigma_dec_c = SIG_POS;
            4'b0110: sigma_dec_c = SIG_NEG;
            default: sigma_dec_c = SIG_ZER;
        endcase
        sigma_d_c   = fault_d_c ? SIG_ZER : sigma_dec_c;
        pos_entry_c = (sigma_d_c == SIG_POS) && (o_sigma != SIG_POS);
    end

    // Period between +1 entries; the first entry after reset or a fault only arms.
    always_ff @(posedge i_clock or negedge i_RESET) begin
        if (!i_RESET) begin
            o_sigma        <= SIG_ZER;
            o_period       <= '0;
            o_period_valid <= 1'b0;
            armed_q        <= 1'b0;
            per_cnt_q      <= '0;
        end else begin
            o_sigma        <= sigma_d_c;
            o_period_valid <= 1'b0;
            if (fault_d_c) begin
                armed_q   <= 1'b0;
                per_cnt_q <= '0;
            end else if (pos_entry_c) begin
                if (armed_q) begin
                    o_period       <= per_cnt_q;
                    o_period_valid <= 1'b1;
                end
                armed_q   <= 1'b1;
                per_cnt_q <= PER_W'(1);
            end else if (armed_q && per_cnt_q != PER_MAX) begin
                per_cnt_q <= per_cnt_q + PER_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_gate_deadtime_driver.sv
// Directed bench for gate_deadtime_driver with hand-computed expectations
// and a per-cycle shoot-through monitor.
module tb_gate_deadtime_driver;

    logic        i_clock;
    logic        i_RESET;
    logic [3:0]  i_MOSFET;
    logic        i_clear_fault;
    logic [3:0]  o_gate;
    logic [1:0]  o_sigma;
    logic        o_fault;
    logic [15:0] o_period;
    logic        o_period_valid;

    int n_tests;
    int n_fail;

    gate_deadtime_driver #(.DEAD_TIME(5)) dut (
        .i_clock        (i_clock),
        .i_RESET        (i_RESET),
        .i_MOSFET       (i_MOSFET),
        .i_clear_fault  (i_clear_fault),
        .o_gate         (o_gate),
        .o_sigma        (o_sigma),
        .o_fault        (o_fault),
        .o_period       (o_period),
        .o_period_valid (o_period_valid)
    );

    initial i_clock = 1'b0;
    always #5 i_clock = ~i_clock;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge i_clock);
        #1;
    endtask

    // Neither leg may ever drive both of its gates.
    always @(negedge i_clock) begin
        check("shoot_a", 32'(o_gate[0] & o_gate[2]), 32'd0);
        check("shoot_b", 32'(o_gate[1] & o_gate[3]), 32'd0);
    end

    logic [3:0] pattern [4];

    initial begin
        n_tests = 0;
        n_fail  = 0;
        pattern[0] = 4'b1001;
        pattern[1] = 4'b0011;
        pattern[2] = 4'b0110;
        pattern[3] = 4'b1100;

        i_RESET       = 1'b0;
        i_MOSFET      = 4'b1001;
        i_clear_fault = 1'b0;
        tick(3);
        check("rst_gate",   32'(o_gate), 32'h0);
        check("rst_sigma",  32'(o_sigma), 32'h0);
        check("rst_fault",  32'(o_fault), 32'h0);
        check("rst_period", 32'(o_period), 32'h0);
        check("rst_valid",  32'(o_period_valid), 32'h0);

        // Release with 1001: sigma after 2 edges, gates after 5.
        i_RESET = 1'b1;
        tick(1);
        check("rel_sigma1", 32'(o_sigma), 32'h0);
        tick(1);
        check("rel_sigma2", 32'(o_sigma), 32'h1);
        check("rel_valid",  32'(o_period_valid), 32'h0);
        tick(2);
        check("rel_gate4",  32'(o_gate), 32'h0);
        tick(1);
        check("rel_gate5",  32'(o_gate), 32'h9);

        // 1001 -> 0011: bit3 falls after 2, bit1 rises 5 later.
        i_MOSFET = 4'b0011;
        tick(1);
        check("c27_gate1", 32'(o_gate), 32'h9);
        tick(1);
        check("c27_gate2", 32'(o_gate), 32'h1);
        check("c27_sigma", 32'(o_sigma), 32'h0);
        tick(4);
        check("c27_gate6", 32'(o_gate), 32'h1);
        tick(1);
        check("c27_gate7", 32'(o_gate), 32'h3);

        // Back to 1001, then a one-cycle glitch to 0110.
        i_MOSFET = 4'b1001;
        tick(7);
        check("c28_settle", 32'(o_gate), 32'h9);
        i_MOSFET = 4'b0110;
        tick(1);
        i_MOSFET = 4'b1001;
        tick(1);
        check("c28_idle",  32'(o_gate), 32'h0);
        check("c28_sigma", 32'(o_sigma), 32'h3);
        tick(4);
        check("c28_gate6", 32'(o_gate), 32'h0);
        tick(1);
        check("c28_gate7", 32'(o_gate), 32'h9);

        // Mid-cycle reset drops gates without waiting for a clock.
        #3;
        i_RESET = 1'b0;
        #1;
        check("async_gate",  32'(o_gate), 32'h0);
        check("async_sigma", 32'(o_sigma), 32'h0);
        i_MOSFET = 4'b0011;
        tick(2);
        i_RESET = 1'b1;
        tick(4);
        check("rrel_gate4", 32'(o_gate), 32'h0);
        tick(1);
        check("rrel_gate5", 32'(o_gate), 32'h3);

        // Shoot-through command on leg A.
        i_MOSFET = 4'b0101;
        tick(1);
        check("f_fault1", 32'(o_fault), 32'h0);
        tick(1);
        check("f_fault2", 32'(o_fault), 32'h1);
        check("f_gate2",  32'(o_gate), 32'h0);
        check("f_sigma2", 32'(o_sigma), 32'h0);
        i_clear_fault = 1'b1;
        tick(1);
        i_clear_fault = 1'b0;
        tick(1);
        check("f_clr_bad", 32'(o_fault), 32'h1);
        i_MOSFET = 4'b1001;
        tick(2);
        check("f_hold",    32'(o_fault), 32'h1);
        check("f_hgate",   32'(o_gate), 32'h0);
        check("f_hsigma",  32'(o_sigma), 32'h0);
        i_clear_fault = 1'b1;
        tick(1);
        check("f_clr_reg", 32'(o_fault), 32'h1);
        i_clear_fault = 1'b0;
        tick(1);
        check("f_cleared", 32'(o_fault), 32'h0);
        check("f_csigma",  32'(o_sigma), 32'h1);
        check("f_cvalid",  32'(o_period_valid), 32'h0);
        check("f_cgate",   32'(o_gate), 32'h0);
        tick(4);
        check("f_gate4",   32'(o_gate), 32'h0);
        tick(1);
        check("f_gate5",   32'(o_gate), 32'h9);

        // Periodic commutation, 100-cycle period, starting from a fresh reset.
        i_RESET  = 1'b0;
        i_MOSFET = 4'b0011;
        tick(2);
        i_RESET = 1'b1;
        tick(10);
        for (int k = 0; k < 4; k++) begin
            for (int c = 0; c < 100; c++) begin
                i_MOSFET = pattern[c / 25];
                tick(1);
                check("per_valid", 32'(o_period_valid), ((k > 0) && (c == 1)) ? 32'h1 : 32'h0);
                if (k > 0 && c == 1)
                    check("per_value", 32'(o_period), 32'd100);
            end
        end

        // Long +1 hold saturates the measured period.
        i_MOSFET = 4'b1001;
        tick(2);
        check("sat_v0", 32'(o_period_valid), 32'h1);
        check("sat_p0", 32'(o_period), 32'd100);
        tick(70000);
        i_MOSFET = 4'b0011;
        tick(5);
        check("sat_keep", 32'(o_period), 32'd100);
        check("sat_nv",   32'(o_period_valid), 32'h0);
        i_MOSFET = 4'b1001;
        tick(2);
        check("sat_v1", 32'(o_period_valid), 32'h1);
        check("sat_p1", 32'(o_period), 32'hFFFF);
        tick(1);
        check("sat_v2", 32'(o_period_valid), 32'h0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/gate_deadtime_driver.md
GATE_DEADTIME_DRIVER -- requirements
Module: gate_deadtime_driver

Interface
REQ-001 Parameter DEAD_TIME, default 5, minimum both-off cycles per leg on every commutation (legal range 1..255; 50 ns at 100 MHz).
REQ-002 i_clock  input  1  system clock; all state updates on its rising edge.
REQ-003 i_RESET  input  1  asynchronous, active-low reset.
REQ-004 i_MOSFET  input  4  raw switch commands from the hybrid controller; leg A = bits {0 high-side, 2 low-side}, leg B = bits {1 high-side, 3 low-side}.
REQ-005 i_clear_fault  input  1  synchronous request to clear a latched fault.
REQ-006 o_gate  output  4  dead-time-protected gate drives, same bit mapping as i_MOSFET.
REQ-007 o_sigma  output  2  decoded switching state, 2-bit two's complement: 01 = +1, 00 = 0, 11 = -1.
REQ-008 o_fault  output  1  latched shoot-through-command fault flag.
REQ-009 o_period  output  16  clock cycles between the two most recent entries into sigma = +1.
REQ-010 o_period_valid  output  1  one-cycle pulse when o_period is updated.

Function
REQ-011 i_MOSFET and i_clear_fault shall be registered once (cmd register); all decisions use the registered copies.
REQ-012 Each leg shall run an independent FSM with states IDLE (both gates 0), ON_H (high gate 1), ON_L (low gate 1), plus an 8-bit dead counter.
REQ-013 ON_H/ON_L: if the leg command differs from the current state, go to IDLE with counter = 0 on the next edge; o_gate turn-off latency is 2 cycles from the i_MOSFET change.
REQ-014 IDLE: counter increments each cycle, saturating at DEAD_TIME; when counter == DEAD_TIME and the leg command is H=1,L=0 go to ON_H, H=0,L=1 go to ON_L, 00 stay IDLE.
REQ-015 Consequence: both gates of a leg shall be 0 for at least DEAD_TIME consecutive cycles between any gate falling and any gate of that leg rising, including the first turn-on after reset.
REQ-016 A command toggling back during IDLE shall not restart the counter; the side commanded when the counter reaches DEAD_TIME is turned on.
REQ-017 o_gate[h] and o_gate[l] of the same leg shall never be 1 simultaneously under any input sequence.
REQ-018 Fault: registered leg command H=1,L=1 on either leg shall set o_fault on the next edge and force both legs to IDLE with counter held at 0 (all o_gate = 0) while o_fault = 1.
REQ-019 o_fault shall clear only when registered i_clear_fault = 1 and neither leg command is 11 in the same cycle; normal operation then resumes with a full DEAD_TIME before any turn-on. Fault and clear in the same cycle: fault wins.
REQ-020 Sigma decode from the registered command: 1001 -> +1, 0110 -> -1, 0011 or 1100 -> 0, any other pattern -> 0; o_sigma = 00 while o_fault = 1; o_sigma is registered (2-cycle latency from i_MOSFET).
REQ-021 Period counter: 16-bit, increments each cycle, saturates at 0xFFFF, resets to 1 on each transition of decoded sigma from non-+1 to +1.
REQ-022 On such a transition o_period shall load the counter value and o_period_valid pulse for one cycle, except for the first +1 entry after reset or after a fault clear (counter only armed then).
REQ-023 During a fault the period counter shall be disarmed; o_period retains its last value.

Reset
REQ-024 While i_RESET = 0: o_gate = 0000, o_sigma = 00, o_fault = 0, o_period = 0, o_period_valid = 0, both FSMs IDLE with counter 0, cmd register 0000, period counter disarmed.
REQ-025 Reset asserted mid-operation shall drop all gates immediately (asynchronously); after release the first turn-on shall still respect a full DEAD_TIME.

Verification
REQ-026 Release reset with i_MOSFET = 1001, DEAD_TIME = 5 -> o_gate = 0000 until o_gate = 1001 appears 5 cycles after IDLE entry; o_sigma = 01 two cycles after release.
REQ-027 Steady 1001 then switch to 0011 -> o_gate[3] falls after 2 cycles, o_gate[1] rises exactly 5 cycles later, o_gate[0] stays 1, o_sigma = 00.
REQ-028 1001 -> 0110 -> 1001 with 1-cycle glitch to 0110 -> both legs IDLE, counters not restarted by glitch, final o_gate = 1001 after DEAD_TIME; no leg ever shows 11.
REQ-029 Apply i_MOSFET = 0101 (leg A both on) -> o_fault = 1 and o_gate = 0000 two cycles later; pulse i_clear_fault while still 0101 -> fault stays; restore 1001 then clear -> fault clears, o_gate = 1001 after DEAD_TIME.
REQ-030 Periodic sequence 1001/0011/0110/1100 with 100-cycle period -> first +1 entry gives no valid; each later entry gives o_period_valid pulse with o_period = 100.
REQ-031 Hold 1001 for 70000 cycles then cycle to +1 again -> o_period = 0xFFFF (saturated).
